// File: rtl/seg_pipe_adder_if.sv
// Operand/result bundle for seg_pipe_adder: issue side (en, in_valid, operands)
// and the registered result side.
interface seg_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output en, in_valid, a, b, cin, sub,
        input  out_valid, s, cout, ovf
    );

    modport slave (
        input  en, in_valid, a, b, cin, sub,
        output out_valid, s, cout, ovf
    );
endinterface

// File: rtl/seg_pipe_adder.sv
// Fully pipelined segmented adder/subtractor: stage k resolves SEG-bit slice k
// using the registered carry of stage k-1, so the carry chain never spans slices.
module seg_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic            clk,
    input logic            rst,
    seg_pipe_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int IW = WIDTH - LO;   // operand bits not yet consumed

        logic [IW-1:0]     a_in;
        logic [IW-1:0]     b_in;
        logic              c_in;
        logic              v_in;
        logic [SEG:0]      sum;
        logic [LO+SEG-1:0] res_d;
        logic [LO+SEG-1:0] res_q;
        logic              c_q;
        logic              v_q;

        assign sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_src
            assign a_in  = bus.a;
            assign b_in  = b_eff;
            assign c_in  = cin_eff;
            assign v_in  = bus.in_valid;
            assign res_d = sum[SEG-1:0];
        end else begin : g_src
            assign a_in  = g_st[k-1].g_up.a_q;
            assign b_in  = g_st[k-1].g_up.b_q;
            assign c_in  = g_st[k-1].c_q;
            assign v_in  = g_st[k-1].v_q;
            assign res_d = {sum[SEG-1:0], g_st[k-1].res_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                res_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
            end else if (bus.en) begin
                res_q <= res_d;
                c_q   <= sum[SEG];
                v_q   <= v_in;
            end
        end

        // Upper slices ride along until their stage; the last stage has none left.
        if (IW > SEG) begin : g_up
            logic [IW-SEG-1:0] a_q;
            logic [IW-SEG-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (bus.en) begin
                    a_q <= a_in[IW-1:SEG];
                    b_q <= b_in[IW-1:SEG];
                end
            end
        end
    end

    // Carry into the MSB is recovered as a^b^sum at that bit.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = g_st[STAGES-1].a_in[SEG-1] ^ g_st[STAGES-1].b_in[SEG-1]
                 ^ g_st[STAGES-1].sum[SEG-1]  ^ g_st[STAGES-1].sum[SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.en) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.out_valid = g_st[STAGES-1].v_q;
    assign bus.s         = g_st[STAGES-1].res_q;
    assign bus.cout      = g_st[STAGES-1].c_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder: default 32/8 instance plus 16/4, 12/12 and
// 64/8 instances for the latency sweep.
module tb_seg_pipe_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_pipe_adder_if #(.WIDTH(32)) d   ();
    seg_pipe_adder_if #(.WIDTH(16)) p16 ();
    seg_pipe_adder_if #(.WIDTH(12)) p12 ();
    seg_pipe_adder_if #(.WIDTH(64)) p64 ();

    seg_pipe_adder #(.WIDTH(32), .SEG(8))  u_dut (.clk(clk), .rst(rst), .bus(d));
    seg_pipe_adder #(.WIDTH(16), .SEG(4))  u_p16 (.clk(clk), .rst(rst), .bus(p16));
    seg_pipe_adder #(.WIDTH(12), .SEG(12)) u_p12 (.clk(clk), .rst(rst), .bus(p12));
    seg_pipe_adder #(.WIDTH(64), .SEG(8))  u_p64 (.clk(clk), .rst(rst), .bus(p64));

    int n_run  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t mdl [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input logic sb);
        exp_t        e;
        logic [32:0] r;
        if (sb) r = {1'b0, a} - {1'b0, b};
        else    r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        e.v = v;
        e.s = r[31:0];
        e.c = sb ? ~r[32] : r[32];
        e.o = sb ? ((a[31] != b[31]) && (r[31] != a[31]))
                 : ((a[31] == b[31]) && (r[31] != a[31]));
        return e;
    endfunction

    // One clock on the 32-bit DUT with a delay-line reference checked after each edge.
    task automatic step(input logic e, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, input logic r);
        d.en = e; d.in_valid = v; d.a = a; d.b = b; d.cin = ci; d.sub = sb; rst = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) mdl[i] = '0;
        end else if (e) begin
            for (int i = 3; i > 0; i--) mdl[i] = mdl[i-1];
            mdl[0] = ref_op(v, a, b, ci, sb);
        end
        #1;
        check("out_valid", {63'd0, d.out_valid}, {63'd0, mdl[3].v});
        if (mdl[3].v) begin
            check("s",    {32'd0, d.s},    {32'd0, mdl[3].s});
            check("cout", {63'd0, d.cout}, {63'd0, mdl[3].c});
            check("ovf",  {63'd0, d.ovf},  {63'd0, mdl[3].o});
        end
    endtask

    task automatic bubble();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb,
                           input logic [31:0] es, input logic ec, input logic eo);
        step(1'b1, 1'b1, a, b, ci, sb, 1'b0);
        bubble();
        bubble();
        check({tag, "_early"}, {63'd0, d.out_valid}, 64'd0);
        bubble();
        check({tag, "_vld"},  {63'd0, d.out_valid}, 64'd1);
        check({tag, "_s"},    {32'd0, d.s},         {32'd0, es});
        check({tag, "_cout"}, {63'd0, d.cout},      {63'd0, ec});
        check({tag, "_ovf"},  {63'd0, d.ovf},       {63'd0, eo});
    endtask

    initial begin
        p16.en = 1'b1; p16.in_valid = 1'b0; p16.a = '0; p16.b = '0; p16.cin = 1'b0; p16.sub = 1'b0;
        p12.en = 1'b1; p12.in_valid = 1'b0; p12.a = '0; p12.b = '0; p12.cin = 1'b0; p12.sub = 1'b0;
        p64.en = 1'b1; p64.in_valid = 1'b0; p64.a = '0; p64.b = '0; p64.cin = 1'b0; p64.sub = 1'b0;

        // Reset, with an in_valid in the reset cycle that must not be captured
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        check("rst_s",    {32'd0, d.s},         64'd0);
        check("rst_cout", {63'd0, d.cout},      64'd0);
        check("rst_ovf",  {63'd0, d.ovf},       64'd0);
        check("rst_p64v", {63'd0, p64.out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) bubble();

        run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("add_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        run_one("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_brw",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_one("sub_eq",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        run_one("sub_cin",  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Streaming: 21 operations, every fourth slot a bubble
        for (int i = 0; i < 28; i++) begin
            logic [31:0] ta, tb;
            logic [31:0] iv;
            iv = 32'(i);
            ta = (32'h9E37_79B9 * (iv + 32'd1)) ^ 32'h5A5A_0000;
            tb = 32'h7F4A_7C15 * (iv + 32'd3);
            if (i % 4 == 3) bubble();
            else            step(1'b1, 1'b1, ta, tb, iv[0], iv[1], 1'b0);
        end
        for (int i = 0; i < 4; i++) bubble();

        // Stall with junk on the inputs while en=0
        step(1'b1, 1'b1, 32'd100,      32'd23,        1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h10,       32'h20,        1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0);
        check("stall_v0", {63'd0, d.out_valid}, 64'd0);
        step(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        check("stall_v1", {63'd0, d.out_valid}, 64'd0);
        bubble();
        check("stall_op0_v", {63'd0, d.out_valid}, 64'd1);
        check("stall_op0_s", {32'd0, d.s},         64'd123);
        step(1'b0, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
        check("stall_keep_v", {63'd0, d.out_valid}, 64'd1);
        check("stall_keep_s", {32'd0, d.s},         64'd123);
        bubble();
        check("stall_op1_s", {32'd0, d.s},    64'h0000_0000_FFFF_FFF0);
        check("stall_op1_c", {63'd0, d.cout}, 64'd0);
        bubble();
        check("stall_op2_s", {32'd0, d.s},    64'h0000_0000_FFFF_FFFF);
        check("stall_op2_c", {63'd0, d.cout}, 64'd1);
        bubble();
        check("stall_done", {63'd0, d.out_valid}, 64'd0);

        // Reset with operations in flight
        step(1'b1, 1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0033, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0055, 32'h0000_0066, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h7777_7777, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("rstmid_v", {63'd0, d.out_valid}, 64'd0);
            check("rstmid_s", {32'd0, d.s},         64'd0);
            check("rstmid_c", {63'd0, d.cout},      64'd0);
            check("rstmid_o", {63'd0, d.ovf},       64'd0);
            bubble();
        end
        run_one("post_rst", 32'h0000_1000, 32'h0000_0234, 1'b1, 1'b0, 32'h0000_1235, 1'b0, 1'b0);

        // Latency sweep: all-ones + 0 + cin=1 on every configuration
        p16.a = '1; p16.b = '0; p16.cin = 1'b1; p16.in_valid = 1'b1;
        p12.a = '1; p12.b = '0; p12.cin = 1'b1; p12.in_valid = 1'b1;
        p64.a = '1; p64.b = '0; p64.cin = 1'b1; p64.in_valid = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            bubble();
            p16.in_valid = 1'b0; p12.in_valid = 1'b0; p64.in_valid = 1'b0;
            check("sw16_v", {63'd0, p16.out_valid}, {63'd0, (t == 4)});
            check("sw12_v", {63'd0, p12.out_valid}, {63'd0, (t == 1)});
            check("sw64_v", {63'd0, p64.out_valid}, {63'd0, (t == 8)});
            if (t == 4) begin
                check("sw16_s", {48'd0, p16.s},    64'd0);
                check("sw16_c", {63'd0, p16.cout}, 64'd1);
                check("sw16_o", {63'd0, p16.ovf},  64'd0);
            end
            if (t == 1) begin
                check("sw12_s", {52'd0, p12.s},    64'd0);
                check("sw12_c", {63'd0, p12.cout}, 64'd1);
                check("sw12_o", {63'd0, p12.ovf},  64'd0);
            end
            if (t == 8) begin
                check("sw64_s", p64.s,             64'd0);
                check("sw64_c", {63'd0, p64.cout}, 64'd1);
                check("sw64_o", {63'd0, p64.ovf},  64'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
